data_bus_interconnect: RTL and testbench
========================================

DATA_BUS_INTERCONNECT -- requirements
Module: data_bus_interconnect

Interface
REQ-001 SHALL take parameter RAM_START, default 32'h00020000, byte base address of data RAM.
REQ-002 SHALL take parameter RAM_DEPTH, default 1024, RAM size in XLEN-bit words.
REQ-003 SHALL take parameter INIT_FILE, default "firmware/firmware_data.hex", RAM init image.
REQ-004 SHALL take parameter NUM_MMIO, default 2, number of MMIO channels (1..8).
REQ-005 SHALL take parameters MMIO_BASE[NUM_MMIO] and MMIO_SIZE[NUM_MMIO] (bytes), defaults {32'h00010000, 32'h00010100} and {256, 256}.
REQ-006 SHALL take parameter TIMEOUT, default 16, maximum MMIO wait cycles.
REQ-007 SHALL have one clock; reset is asynchronous and active-low; ports are clock (in, 1) and reset_n (in, 1).
REQ-008 Request ports: req_valid in 1; req_ready out 1; req_addr in XLEN; req_w_data in XLEN; req_w_width in write_width_t; req_w_enable in 1.
REQ-009 Response ports: resp_valid out 1; resp_r_data out XLEN; resp_fault out 1.
REQ-010 MMIO ports: mmio_sel out NUM_MMIO (one-hot); mmio_control out mem_write_control_t; mmio_ack in NUM_MMIO; mmio_r_data in NUM_MMIO x XLEN.

Function
REQ-011 SHALL implement FSM states IDLE, RAM_ACCESS, MMIO_WAIT, RESP; req_ready = 1 only in IDLE.
REQ-012 Accept = req_valid && req_ready; on accept, address, data, width and enable SHALL be latched.
REQ-013 Decode: RAM window [RAM_START, RAM_START+4*RAM_DEPTH) has priority; otherwise lowest-index MMIO window containing the address; no match -> fault.
REQ-014 Writes with half width at odd address, or word width with addr[1:0] != 0, SHALL fault; no RAM write and no mmio_sel.
REQ-015 RAM hit: write (if enabled) performed in the accept cycle at addr - RAM_START; IDLE -> RAM_ACCESS -> RESP; resp_valid exactly 2 cycles after accept; read data = RAM word at latched address.
REQ-016 MMIO hit: IDLE -> MMIO_WAIT; mmio_sel[i] high and mmio_control (addr, value, width, enable = latched w_enable) held stable from the cycle after accept until ack or timeout.
REQ-017 In MMIO_WAIT, mmio_ack[i] high on the selected channel SHALL capture mmio_r_data[i] into resp_r_data, drop mmio_sel next cycle, go to RESP; acks on unselected channels ignored.
REQ-018 Wait counter SHALL clear on entering MMIO_WAIT and increment each cycle; at count == TIMEOUT-1 without ack -> RESP with fault.
REQ-019 Ack and timeout in the same cycle: ack wins, no fault.
REQ-020 RESP: resp_valid = 1 for exactly one cycle, no back-pressure; then IDLE.
REQ-021 Fault response: resp_fault = 1, resp_r_data = 0; fault reaches RESP one cycle after accept for decode/misalign faults.
REQ-022 resp_r_data and resp_fault SHALL be valid only while resp_valid = 1 and hold 0 otherwise.
REQ-023 Address subtraction/compare SHALL be XLEN-bit unsigned; windows ending at 2^XLEN SHALL not wrap.

Reset
REQ-024 reset_n low SHALL asynchronously force IDLE, req_ready = 1 (after release), resp_valid = 0, resp_fault = 0, resp_r_data = 0, mmio_sel = 0, mmio_control.enable = 0, wait counter = 0.
REQ-025 Reset during MMIO_WAIT or RAM_ACCESS SHALL abandon the transaction with no response; RAM contents are not reset.

Structure
REQ-026 write_width_t, mem_write_control_t, XLEN and a new bus_state_t enum SHALL live in the shared package.
REQ-027 Data storage SHALL be the existing ram sub-module instantiated once; decode and FSM in this module.

Verification
REQ-028 RAM word write 0xDEADBEEF at 0x00020010, then read -> resp_valid 2 cycles after each accept, read data 0xDEADBEEF, fault 0.
REQ-029 Read 0x00010004 with channel 0 acking after 3 cycles, data 0x12345678 -> mmio_sel = 01 for 3 cycles, resp data 0x12345678.
REQ-030 Read 0x00010200 (unmapped) -> resp_valid with fault 1, data 0, mmio_sel never set.
REQ-031 Word write at 0x00020002 -> fault 1; following read of 0x00020000 returns prior contents.
REQ-032 Channel 1 access, no ack, TIMEOUT = 16 -> fault on 17th cycle after accept; ack on cycle 16 instead -> no fault.
REQ-033 reset_n pulsed low mid MMIO_WAIT -> mmio_sel = 0 immediately, no resp_valid, next request served normally.

Source files
------------

// File: rtl/data_bus_interconnect_pkg.sv
// rtl/data_bus_interconnect_pkg.sv - shared types and lane helpers for the data bus interconnect
package data_bus_interconnect_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    W_BYTE = 2'd0,
    W_HALF = 2'd1,
    W_WORD = 2'd2
  } write_width_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] value;
    write_width_t    width;
    logic            enable;
  } mem_write_control_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RAM_ACCESS = 2'd1,
    ST_MMIO_WAIT  = 2'd2,
    ST_RESP       = 2'd3
  } bus_state_t;

  // Byte-lane enables for a store of the given width at byte offset a.
  function automatic logic [3:0] lane_be(write_width_t w, logic [1:0] a);
    case (w)
      W_BYTE:  return 4'b0001 << a;
      W_HALF:  return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data arrives right-aligned; replicate it so every enabled lane sees it.
  function automatic logic [XLEN-1:0] lane_data(write_width_t w, logic [XLEN-1:0] d);
    case (w)
      W_BYTE:  return {4{d[7:0]}};
      W_HALF:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/data_bus_interconnect_if.sv
// rtl/data_bus_interconnect_if.sv - request/response and MMIO channel bundle
interface data_bus_interconnect_if
  import data_bus_interconnect_pkg::*;
#(
  parameter int NUM_MMIO = 2
);

  logic                           req_valid;
  logic                           req_ready;
  logic [XLEN-1:0]                req_addr;
  logic [XLEN-1:0]                req_w_data;
  write_width_t                   req_w_width;
  logic                           req_w_enable;

  logic                           resp_valid;
  logic [XLEN-1:0]                resp_r_data;
  logic                           resp_fault;

  logic [NUM_MMIO-1:0]            mmio_sel;
  mem_write_control_t             mmio_control;
  logic [NUM_MMIO-1:0]            mmio_ack;
  logic [NUM_MMIO-1:0][XLEN-1:0]  mmio_r_data;

  // Requester / peripheral side (the environment around the interconnect).
  modport master (
    output req_valid, req_addr, req_w_data, req_w_width, req_w_enable,
    output mmio_ack, mmio_r_data,
    input  req_ready, resp_valid, resp_r_data, resp_fault,
    input  mmio_sel, mmio_control
  );

  // Interconnect side.
  modport slave (
    input  req_valid, req_addr, req_w_data, req_w_width, req_w_enable,
    input  mmio_ack, mmio_r_data,
    output req_ready, resp_valid, resp_r_data, resp_fault,
    output mmio_sel, mmio_control
  );

endinterface

// File: rtl/data_bus_interconnect_ram.sv
// rtl/data_bus_interconnect_ram.sv - byte-lane writable data RAM with combinational read
module data_bus_interconnect_ram
  import data_bus_interconnect_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int AW        = 10,
  parameter     INIT_FILE = ""
) (
  input  logic            clock,
  input  logic            i_we,
  input  logic [3:0]      i_be,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr,
  output logic [XLEN-1:0] o_rdata
);

  // Contents are not reset; INIT_FILE names the preload image applied by the
  // memory-initialisation step of the build flow.
  logic [XLEN-1:0] r_mem [DEPTH];

  // Per-lane write so byte and half stores leave the other lanes untouched.
  always_ff @(posedge clock) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_bus_interconnect.sv
// rtl/data_bus_interconnect.sv - address decode, RAM/MMIO routing and response FSM
module data_bus_interconnect
  import data_bus_interconnect_pkg::*;
#(
  parameter logic [XLEN-1:0] RAM_START           = 32'h00020000,
  parameter int              RAM_DEPTH           = 1024,
  parameter                  INIT_FILE           = "firmware/firmware_data.hex",
  parameter int              NUM_MMIO            = 2,
  parameter logic [XLEN-1:0] MMIO_BASE [NUM_MMIO] = '{32'h00010000, 32'h00010100},
  parameter logic [XLEN-1:0] MMIO_SIZE [NUM_MMIO] = '{32'd256, 32'd256},
  parameter int              TIMEOUT             = 16
) (
  input logic                   clock,
  input logic                   reset_n,
  data_bus_interconnect_if.slave bus
);

  localparam int AW     = $clog2(RAM_DEPTH);
  localparam int IDX_W  = (NUM_MMIO > 1) ? $clog2(NUM_MMIO) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT) + 1;
  // One extra bit so a window ending exactly at 2^XLEN does not wrap to zero.
  localparam logic [XLEN:0] RAM_BYTES = (XLEN+1)'(RAM_DEPTH) << 2;

  bus_state_t          r_state;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic                r_resp_fault;
  logic [XLEN-1:0]     r_resp_rdata;
  logic [NUM_MMIO-1:0] r_mmio_sel;
  mem_write_control_t  r_ctrl;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [AW-1:0]       r_ram_idx;
  logic [IDX_W-1:0]    r_mmio_idx;

  logic                w_accept;
  logic [XLEN-1:0]     w_ram_off;
  logic                w_ram_hit;
  logic                w_mmio_hit;
  logic [IDX_W-1:0]    w_mmio_idx;
  logic                w_misalign;
  logic                w_fault;
  logic                w_ram_we;
  logic [XLEN-1:0]     w_ram_rdata;

  assign w_accept = bus.req_valid && r_req_ready;

  // Decode the live request address: RAM first, then the lowest-index MMIO window.
  always_comb begin
    w_ram_off  = bus.req_addr - RAM_START;
    w_ram_hit  = (bus.req_addr >= RAM_START) && ({1'b0, w_ram_off} < RAM_BYTES);
    w_mmio_hit = 1'b0;
    w_mmio_idx = '0;
    for (int i = NUM_MMIO - 1; i >= 0; i--) begin
      if ((bus.req_addr >= MMIO_BASE[i]) &&
          ({1'b0, bus.req_addr - MMIO_BASE[i]} < {1'b0, MMIO_SIZE[i]})) begin
        w_mmio_hit = 1'b1;
        w_mmio_idx = IDX_W'(i);
      end
    end
    w_misalign = bus.req_w_enable &&
                 (((bus.req_w_width == W_HALF) && bus.req_addr[0]) ||
                  ((bus.req_w_width == W_WORD) && (bus.req_addr[1:0] != 2'b00)));
    w_fault    = w_misalign || (!w_ram_hit && !w_mmio_hit);
  end

  // The RAM store happens on the accept edge itself, straight from the request.
  assign w_ram_we = w_accept && w_ram_hit && !w_misalign && bus.req_w_enable;

  data_bus_interconnect_ram #(
    .DEPTH     (RAM_DEPTH),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clock   (clock),
    .i_we    (w_ram_we),
    .i_be    (lane_be(bus.req_w_width, bus.req_addr[1:0])),
    .i_waddr (w_ram_off[AW+1:2]),
    .i_wdata (lane_data(bus.req_w_width, bus.req_w_data)),
    .i_raddr (r_ram_idx),
    .o_rdata (w_ram_rdata)
  );

  // Transaction FSM; every bus-facing output is a register updated here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_rdata <= '0;
      r_mmio_sel   <= '0;
      r_ctrl       <= '0;
      r_wait_cnt   <= '0;
      r_ram_idx    <= '0;
      r_mmio_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_ready  <= 1'b0;
            r_ctrl.addr  <= bus.req_addr;
            r_ctrl.value <= bus.req_w_data;
            r_ctrl.width <= bus.req_w_width;
            r_ram_idx    <= w_ram_off[AW+1:2];
            r_mmio_idx   <= w_mmio_idx;
            r_wait_cnt   <= '0;
            if (w_fault) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_fault <= 1'b1;
              r_resp_rdata <= '0;
              r_ctrl.enable <= 1'b0;
            end else if (w_ram_hit) begin
              r_state       <= ST_RAM_ACCESS;
              r_ctrl.enable <= 1'b0;
            end else begin
              r_state       <= ST_MMIO_WAIT;
              r_mmio_sel    <= NUM_MMIO'(1) << w_mmio_idx;
              r_ctrl.enable <= bus.req_w_enable;
            end
          end
        end

        ST_RAM_ACCESS: begin
          r_state      <= ST_RESP;
          r_resp_valid <= 1'b1;
          r_resp_fault <= 1'b0;
          r_resp_rdata <= w_ram_rdata;
        end

        ST_MMIO_WAIT: begin
          // An ack on the selected channel beats a timeout in the same cycle.
          if (bus.mmio_ack[r_mmio_idx]) begin
            r_state       <= ST_RESP;
            r_resp_valid  <= 1'b1;
            r_resp_fault  <= 1'b0;
            r_resp_rdata  <= bus.mmio_r_data[r_mmio_idx];
            r_mmio_sel    <= '0;
            r_ctrl.enable <= 1'b0;
          end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state       <= ST_RESP;
            r_resp_valid  <= 1'b1;
            r_resp_fault  <= 1'b1;
            r_resp_rdata  <= '0;
            r_mmio_sel    <= '0;
            r_ctrl.enable <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        ST_RESP: begin
          r_state      <= ST_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_fault <= 1'b0;
          r_resp_rdata <= '0;
        end

        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready    = r_req_ready;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_fault   = r_resp_fault;
  assign bus.resp_r_data  = r_resp_rdata;
  assign bus.mmio_sel     = r_mmio_sel;
  assign bus.mmio_control = r_ctrl;

endmodule

// File: tb/tb_data_bus_interconnect.sv
// tb/tb_data_bus_interconnect.sv - directed self-checking bench for data_bus_interconnect
module tb_data_bus_interconnect;
  import data_bus_interconnect_pkg::*;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  data_bus_interconnect_if #(.NUM_MMIO(2)) bus ();

  data_bus_interconnect #(.INIT_FILE("")) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int                 g_lat;
  int                 g_nresp;
  int                 g_sel_cycles;
  int                 g_dirty;
  logic               g_flt;
  logic [31:0]        g_rdata;
  logic [1:0]         g_sel_seen;
  logic               g_ready0;
  logic               g_ready_c1;
  mem_write_control_t g_ctrl;

  // Issue one request and observe ncyc cycles after the accept edge.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] data, input write_width_t w,
                         input logic we, input int ack_ch, input int ack_at,
                         input logic [31:0] ack_data, input int noise_at);
    @(negedge clock);
    g_ready0         = bus.req_ready;
    bus.req_addr     = addr;
    bus.req_w_data   = data;
    bus.req_w_width  = w;
    bus.req_w_enable = we;
    bus.req_valid    = 1'b1;
    @(posedge clock);
    #1;
    bus.req_valid    = 1'b0;
    g_lat = 0; g_nresp = 0; g_sel_cycles = 0; g_dirty = 0;
    g_flt = 1'b0; g_rdata = '0; g_sel_seen = '0; g_ready_c1 = 1'b1; g_ctrl = '0;
    for (int c = 1; c <= 24; c++) begin
      bus.mmio_ack = '0;
      if (c == ack_at) begin
        bus.mmio_ack[ack_ch]    = 1'b1;
        bus.mmio_r_data[ack_ch] = ack_data;
      end
      if (c == noise_at) begin
        bus.mmio_ack[1-ack_ch]    = 1'b1;
        bus.mmio_r_data[1-ack_ch] = 32'hBADBAD00;
      end
      @(negedge clock);
      if (c == 1) begin
        g_ready_c1 = bus.req_ready;
        g_ctrl     = bus.mmio_control;
      end
      if (bus.mmio_sel != '0) begin
        g_sel_cycles++;
        g_sel_seen |= bus.mmio_sel;
      end
      if (bus.resp_valid) begin
        g_nresp++;
        if (g_lat == 0) begin
          g_lat   = c;
          g_flt   = bus.resp_fault;
          g_rdata = bus.resp_r_data;
        end
      end else if (bus.resp_fault || (bus.resp_r_data != '0)) begin
        g_dirty++;
      end
      @(posedge clock);
      #1;
    end
    bus.mmio_ack = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    checks++; if (bus.resp_fault !== 1'b0) begin failures++; $display("FAIL reset_resp_fault got=%b exp=0", bus.resp_fault); end
    checks++; if (bus.resp_r_data !== 32'h0) begin failures++; $display("FAIL reset_resp_data got=%h exp=0", bus.resp_r_data); end
    checks++; if (bus.mmio_sel !== 2'b00) begin failures++; $display("FAIL reset_mmio_sel got=%b exp=00", bus.mmio_sel); end
    checks++; if (bus.mmio_control.enable !== 1'b0) begin failures++; $display("FAIL reset_ctrl_enable got=%b exp=0", bus.mmio_control.enable); end
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_ram();
    run_txn(32'h00020010, 32'hDEADBEEF, W_WORD, 1'b1, 0, 0, 0, 0);
    checks++; if (g_ready0 !== 1'b1) begin failures++; $display("FAIL ram_wr_ready got=%b exp=1", g_ready0); end
    checks++; if (g_ready_c1 !== 1'b0) begin failures++; $display("FAIL ram_wr_busy got=%b exp=0", g_ready_c1); end
    checks++; if (g_lat !== 2) begin failures++; $display("FAIL ram_wr_latency got=%0d exp=2", g_lat); end
    checks++; if (g_flt !== 1'b0) begin failures++; $display("FAIL ram_wr_fault got=%b exp=0", g_flt); end
    checks++; if (g_sel_cycles !== 0) begin failures++; $display("FAIL ram_wr_sel got=%0d exp=0", g_sel_cycles); end
    run_txn(32'h00020010, 32'h0, W_WORD, 1'b0, 0, 0, 0, 0);
    checks++; if (g_lat !== 2) begin failures++; $display("FAIL ram_rd_latency got=%0d exp=2", g_lat); end
    checks++; if (g_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ram_rd_data got=%h exp=deadbeef", g_rdata); end
    checks++; if (g_flt !== 1'b0) begin failures++; $display("FAIL ram_rd_fault got=%b exp=0", g_flt); end
    checks++; if (g_nresp !== 1) begin failures++; $display("FAIL ram_rd_resp_count got=%0d exp=1", g_nresp); end
    checks++; if (g_dirty !== 0) begin failures++; $display("FAIL ram_rd_idle_outputs got=%0d exp=0", g_dirty); end
    run_txn(32'h00020011, 32'h000000A5, W_BYTE, 1'b1, 0, 0, 0, 0);
    run_txn(32'h00020012, 32'h00001234, W_HALF, 1'b1, 0, 0, 0, 0);
    run_txn(32'h00020010, 32'h0, W_WORD, 1'b0, 0, 0, 0, 0);
    checks++; if (g_rdata !== 32'h1234A5EF) begin failures++; $display("FAIL ram_lanes_data got=%h exp=1234a5ef", g_rdata); end
    run_txn(32'h00020FFC, 32'h0, W_WORD, 1'b0, 0, 0, 0, 0);
    checks++; if ((g_lat !== 2) || (g_flt !== 1'b0)) begin failures++; $display("FAIL ram_last_word got=lat%0d/f%b exp=lat2/f0", g_lat, g_flt); end
  endtask

  task automatic test_mmio();
    run_txn(32'h00010004, 32'h0, W_WORD, 1'b0, 0, 3, 32'h12345678, 2);
    checks++; if (g_sel_cycles !== 3) begin failures++; $display("FAIL mmio_sel_cycles got=%0d exp=3", g_sel_cycles); end
    checks++; if (g_sel_seen !== 2'b01) begin failures++; $display("FAIL mmio_sel_value got=%b exp=01", g_sel_seen); end
    checks++; if (g_lat !== 4) begin failures++; $display("FAIL mmio_latency got=%0d exp=4", g_lat); end
    checks++; if (g_rdata !== 32'h12345678) begin failures++; $display("FAIL mmio_rd_data got=%h exp=12345678", g_rdata); end
    checks++; if (g_flt !== 1'b0) begin failures++; $display("FAIL mmio_rd_fault got=%b exp=0", g_flt); end
    checks++; if ((g_ctrl.addr !== 32'h00010004) || (g_ctrl.enable !== 1'b0)) begin failures++; $display("FAIL mmio_rd_ctrl got=%h/%b exp=00010004/0", g_ctrl.addr, g_ctrl.enable); end
    run_txn(32'h0001010C, 32'h0A0B0C0D, W_WORD, 1'b1, 1, 1, 32'h0, 0);
    checks++; if (g_sel_seen !== 2'b10) begin failures++; $display("FAIL mmio_wr_sel got=%b exp=10", g_sel_seen); end
    checks++; if ((g_ctrl.enable !== 1'b1) || (g_ctrl.value !== 32'h0A0B0C0D) || (g_ctrl.width !== W_WORD) || (g_ctrl.addr !== 32'h0001010C)) begin
      failures++; $display("FAIL mmio_wr_ctrl got=%h/%h/%0d/%b exp=0001010c/0a0b0c0d/2/1", g_ctrl.addr, g_ctrl.value, g_ctrl.width, g_ctrl.enable); end
    checks++; if ((g_lat !== 2) || (g_flt !== 1'b0)) begin failures++; $display("FAIL mmio_wr_resp got=lat%0d/f%b exp=lat2/f0", g_lat, g_flt); end
  endtask

  task automatic test_unmapped();
    run_txn(32'h00010200, 32'h0, W_WORD, 1'b0, 0, 0, 0, 0);
    checks++; if (g_lat !== 1) begin failures++; $display("FAIL unmapped_latency got=%0d exp=1", g_lat); end
    checks++; if ((g_flt !== 1'b1) || (g_rdata !== 32'h0)) begin failures++; $display("FAIL unmapped_resp got=f%b/%h exp=f1/0", g_flt, g_rdata); end
    checks++; if (g_sel_cycles !== 0) begin failures++; $display("FAIL unmapped_sel got=%0d exp=0", g_sel_cycles); end
    run_txn(32'h00021000, 32'h0, W_WORD, 1'b0, 0, 0, 0, 0);
    checks++; if ((g_lat !== 1) || (g_flt !== 1'b1)) begin failures++; $display("FAIL ram_end_edge got=lat%0d/f%b exp=lat1/f1", g_lat, g_flt); end
    run_txn(32'hFFFFFFFC, 32'h0, W_WORD, 1'b0, 0, 0, 0, 0);
    checks++; if (g_flt !== 1'b1) begin failures++; $display("FAIL top_of_space got=f%b exp=f1", g_flt); end
  endtask

  task automatic test_misalign();
    run_txn(32'h00020000, 32'h11223344, W_WORD, 1'b1, 0, 0, 0, 0);
    run_txn(32'h00020002, 32'hFFFFFFFF, W_WORD, 1'b1, 0, 0, 0, 0);
    checks++; if ((g_lat !== 1) || (g_flt !== 1'b1) || (g_rdata !== 32'h0)) begin failures++; $display("FAIL misalign_word got=lat%0d/f%b/%h exp=lat1/f1/0", g_lat, g_flt, g_rdata); end
    run_txn(32'h00020001, 32'h0000FFFF, W_HALF, 1'b1, 0, 0, 0, 0);
    checks++; if (g_flt !== 1'b1) begin failures++; $display("FAIL misalign_half got=f%b exp=f1", g_flt); end
    run_txn(32'h00020000, 32'h0, W_WORD, 1'b0, 0, 0, 0, 0);
    checks++; if (g_rdata !== 32'h11223344) begin failures++; $display("FAIL misalign_no_write got=%h exp=11223344", g_rdata); end
    run_txn(32'h00010001, 32'h0000FFFF, W_HALF, 1'b1, 0, 1, 32'h0, 0);
    checks++; if ((g_flt !== 1'b1) || (g_sel_cycles !== 0)) begin failures++; $display("FAIL misalign_mmio got=f%b/sel%0d exp=f1/sel0", g_flt, g_sel_cycles); end
  endtask

  task automatic test_timeout();
    run_txn(32'h00010108, 32'h0, W_WORD, 1'b0, 1, 0, 0, 0);
    checks++; if (g_lat !== 17) begin failures++; $display("FAIL timeout_latency got=%0d exp=17", g_lat); end
    checks++; if ((g_flt !== 1'b1) || (g_rdata !== 32'h0)) begin failures++; $display("FAIL timeout_resp got=f%b/%h exp=f1/0", g_flt, g_rdata); end
    checks++; if ((g_sel_cycles !== 16) || (g_sel_seen !== 2'b10)) begin failures++; $display("FAIL timeout_sel got=%0d/%b exp=16/10", g_sel_cycles, g_sel_seen); end
    run_txn(32'h00010108, 32'h0, W_WORD, 1'b0, 1, 16, 32'hCAFEF00D, 0);
    checks++; if ((g_lat !== 17) || (g_flt !== 1'b0) || (g_rdata !== 32'hCAFEF00D)) begin failures++; $display("FAIL ack_at_limit got=lat%0d/f%b/%h exp=lat17/f0/cafef00d", g_lat, g_flt, g_rdata); end
  endtask

  task automatic test_reset_mid();
    int nresp;
    @(negedge clock);
    bus.req_addr     = 32'h00010000;
    bus.req_w_width  = W_WORD;
    bus.req_w_enable = 1'b0;
    bus.req_valid    = 1'b1;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++; if (bus.mmio_sel !== 2'b01) begin failures++; $display("FAIL midreset_sel_before got=%b exp=01", bus.mmio_sel); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ((bus.mmio_sel !== 2'b00) || (bus.mmio_control.enable !== 1'b0)) begin failures++; $display("FAIL midreset_sel_async got=%b/%b exp=00/0", bus.mmio_sel, bus.mmio_control.enable); end
    @(negedge clock);
    reset_n = 1'b1;
    nresp = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (bus.resp_valid) nresp++;
    end
    checks++; if (nresp !== 0) begin failures++; $display("FAIL midreset_no_resp got=%0d exp=0", nresp); end
    run_txn(32'h00020010, 32'h0, W_WORD, 1'b0, 0, 0, 0, 0);
    checks++; if ((g_ready0 !== 1'b1) || (g_lat !== 2) || (g_rdata !== 32'h1234A5EF)) begin failures++; $display("FAIL midreset_next got=r%b/lat%0d/%h exp=r1/lat2/1234a5ef", g_ready0, g_lat, g_rdata); end
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    reset_n          = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_addr     = '0;
    bus.req_w_data   = '0;
    bus.req_w_width  = W_WORD;
    bus.req_w_enable = 1'b0;
    bus.mmio_ack     = '0;
    bus.mmio_r_data  = '0;
    test_reset();
    test_ram();
    test_mmio();
    test_unmapped();
    test_misalign();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
